// File: rtl/pwm_tx.sv
// pwm_tx: double-buffered high/low pulse generator; new configs take effect at period boundaries.
// Define PWM_TX_BURST_EN to add burst_len/burst_done (stop after a fixed number of periods).
module pwm_tx #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [CW-1:0] cfg_high,
    input  logic [CW-1:0] cfg_low,
    input  logic          cfg_load,
`ifdef PWM_TX_BURST_EN
    input  logic [15:0]   burst_len,
    output logic          burst_done,
`endif
    output logic          sig_out,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic          period_done,
    output logic          busy,
    output logic          cfg_pending
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] pend_h, pend_l, act_h, act_l;
    logic [CW-1:0] act_h_nx, act_l_nx, new_h, new_l;
    logic          pending_nx, sig_nx, done_nx;
    logic          period_end, idle_start, start;
    logic          burst_final, armed;

    always_comb begin
        // a strobe coinciding with a period start wins over the older pending values
        new_h      = cfg_load ? cfg_high : pend_h;
        new_l      = cfg_load ? cfg_low  : pend_l;
        period_end = ((state == HIGH) && (cnt == act_h) && (act_l == '0)) ||
                     ((state == LOW) && (cnt == act_l));
        idle_start = (state == IDLE) && enable && armed && ((new_h | new_l) != '0);
        start      = idle_start || (period_end && enable && !burst_final);

        state_nx   = state;
        cnt_nx     = cnt;
        act_h_nx   = act_h;
        act_l_nx   = act_l;
        pending_nx = cfg_pending | cfg_load;
        sig_nx     = sig_out;

        case (state)
            HIGH: begin
                if (cnt != act_h) begin
                    cnt_nx = cnt + ONE;
                end else if (act_l != '0) begin
                    state_nx = LOW;
                    cnt_nx   = ONE;
                    sig_nx   = 1'b0;
                end
            end
            LOW: begin
                if (cnt != act_l) cnt_nx = cnt + ONE;
            end
            default: ;
        endcase

        if (period_end) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            sig_nx   = 1'b0;
        end

        if (start) begin
            act_h_nx   = new_h;
            act_l_nx   = new_l;
            pending_nx = 1'b0;
            if (new_h != '0) begin
                state_nx = HIGH;
                cnt_nx   = ONE;
                sig_nx   = 1'b1;
            end else if (new_l != '0) begin
                state_nx = LOW;
                cnt_nx   = ONE;
                sig_nx   = 1'b0;
            end else begin
                state_nx = IDLE;
                cnt_nx   = '0;
                sig_nx   = 1'b0;
            end
        end

        // registered flag: asserted for the clock that will be the last of its period
        done_nx = ((state_nx == HIGH) && (cnt_nx == act_h_nx) && (act_l_nx == '0)) ||
                  ((state_nx == LOW) && (cnt_nx == act_l_nx));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_h      <= '0;
            pend_l      <= '0;
            act_h       <= '0;
            act_l       <= '0;
            cfg_pending <= 1'b0;
            sig_out     <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            if (cfg_load) begin
                pend_h <= cfg_high;
                pend_l <= cfg_low;
            end
            act_h       <= act_h_nx;
            act_l       <= act_l_nx;
            cfg_pending <= pending_nx;
            sig_out     <= sig_nx;
            rise_pulse  <= sig_nx & ~sig_out;
            fall_pulse  <= ~sig_nx & sig_out;
            period_done <= done_nx;
        end
    end

    assign busy = (state != IDLE);

`ifdef PWM_TX_BURST_EN
    logic [15:0] b_rem, b_rem_nx;
    logic        b_cont, b_cont_nx, b_lock, b_lock_nx, b_done_nx;

    assign burst_final = !b_cont && (b_rem == 16'd1);
    assign armed       = !b_lock;

    always_comb begin
        b_rem_nx  = b_rem;
        b_cont_nx = b_cont;
        // lock holds off re-arming until enable has been seen low
        b_lock_nx = (b_lock || (period_end && burst_final)) && enable;
        if (idle_start) begin
            b_rem_nx  = burst_len;
            b_cont_nx = (burst_len == 16'd0);
        end else if (period_end && !b_cont) begin
            b_rem_nx = b_rem - 16'd1;
        end
        b_done_nx = done_nx && !b_cont_nx && (b_rem_nx == 16'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rem      <= '0;
            b_cont     <= 1'b0;
            b_lock     <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            b_rem      <= b_rem_nx;
            b_cont     <= b_cont_nx;
            b_lock     <= b_lock_nx;
            burst_done <= b_done_nx;
        end
    end
`else
    assign burst_final = 1'b0;
    assign armed       = 1'b1;
`endif

endmodule

// File: tb/tb_pwm_tx.sv
// tb_pwm_tx: directed and randomized stimulus for pwm_tx against a period-position model.
// With PWM_TX_BURST_EN defined, a directed burst scenario is added.
module tb_pwm_tx;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [CW-1:0] cfg_high, cfg_low;
    logic          cfg_load;
    logic          sig_out, rise_pulse, fall_pulse, period_done, busy, cfg_pending;
`ifdef PWM_TX_BURST_EN
    logic [15:0]   burst_len;
    logic          burst_done;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_tx #(.CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .cfg_load   (cfg_load),
`ifdef PWM_TX_BURST_EN
        .burst_len  (burst_len),
        .burst_done (burst_done),
`endif
        .sig_out    (sig_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .period_done(period_done),
        .busy       (busy),
        .cfg_pending(cfg_pending)
    );

    // reference: position within the running period plus active/pending lengths
    bit     m_run, m_pend, m_sig, m_sig_prev;
    longint m_pos, m_ah, m_al, m_ph, m_pl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_pend = 0; m_sig = 0; m_sig_prev = 0;
        m_pos = 0; m_ah = 0; m_al = 0; m_ph = 0; m_pl = 0;
    endfunction

    function automatic void model_edge();
        longint nh, nl;
        bit     last;
        nh = cfg_load ? longint'(cfg_high) : m_ph;
        nl = cfg_load ? longint'(cfg_low)  : m_pl;
        if (cfg_load) begin
            m_ph = nh; m_pl = nl; m_pend = 1;
        end
        m_sig_prev = m_sig;
        last = m_run && (m_pos == m_ah + m_al - 1);
        if (m_run && !last) begin
            m_pos++;
        end else if (enable && (m_run || (nh + nl != 0))) begin
            m_ah = nh; m_al = nl; m_pend = 0; m_pos = 0;
            m_run = (nh + nl) != 0;
        end else begin
            m_run = 0;
        end
        m_sig = m_run && (m_pos < m_ah);
    endfunction

    task automatic check_outputs();
        chk("sig_out", sig_out, m_sig);
        chk("rise_pulse", rise_pulse, m_sig && !m_sig_prev);
        chk("fall_pulse", fall_pulse, !m_sig && m_sig_prev);
        chk("period_done", period_done, m_run && (m_pos == m_ah + m_al - 1));
        chk("busy", busy, m_run);
        chk("cfg_pending", cfg_pending, m_pend);
    endtask

    // called just after a falling edge; returns just after the next falling edge
    task automatic step(input bit en, input bit ld, input int h, input int l);
        enable   = en;
        cfg_load = ld;
        cfg_high = CW'(h);
        cfg_low  = CW'(l);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cfg_load = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_sig", sig_out, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_done", period_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", cfg_pending, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pd, rc, fc, hi;
        rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_high = '0; cfg_low = '0;
`ifdef PWM_TX_BURST_EN
        burst_len = 16'd0;
`endif
        @(negedge clk);
        do_reset();

        // 3/5 duty
        step(0, 1, 3, 5);
        pd = 0; rc = 0; fc = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, 0, $urandom_range(0, 9), $urandom_range(0, 9));
            pd += int'(period_done); rc += int'(rise_pulse); fc += int'(fall_pulse);
        end
        chk("duty_period_done", pd, 3);
        chk("duty_rise", rc, 3);
        chk("duty_fall", fc, 3);

        // reconfigure to 2/2 during HIGH
        step(1, 0, 0, 0);
        step(1, 1, 2, 2);
        chk("reconf_pending", cfg_pending, 1);
        for (int i = 0; i < 18; i++) step(1, 0, 7, 7);

        // stop with enable low from the 2nd low clock of a 3/5 period
        step(1, 1, 3, 5);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1);
            chk("stop_busy", busy, (i < 3) ? 1 : 0);
        end

        // high=0, low=4
        step(1, 1, 0, 4);
        pd = 0; hi = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 5, 5);
            pd += int'(period_done); hi += int'(sig_out);
        end
        chk("zero_h_done", pd, 3);
        chk("zero_h_sig", hi, 0);

        // high=4, low=0 queued mid-period
        step(1, 1, 4, 0);
        pd = 0; hi = 0; fc = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 5, 5);
            pd += int'(period_done); hi += int'(sig_out); fc += int'(fall_pulse);
        end
        chk("zero_l_done", pd, 4);
        chk("zero_l_sig", hi, 14);
        chk("zero_l_fall", fc, 0);

        // 0/0 returns to idle
        step(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 3, 3);
        chk("zero_both_busy", busy, 0);

        // reset during HIGH of 10/10
        step(1, 1, 10, 10);
        for (int i = 0; i < 3; i++) step(1, 0, 10, 10);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 6, 6);
            chk("post_rst_idle", busy, 0);
        end

        // randomized traffic
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit en, ld;
            en = ($urandom_range(0, 19) == 0) ? !enable : enable;
            ld = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(en, ld, $urandom_range(0, 6), $urandom_range(0, 6));
        end

`ifdef PWM_TX_BURST_EN
        begin
            int bz, bd, co;
            enable = 1'b0;
            do_reset();
            cfg_high = CW'(2); cfg_low = CW'(2); cfg_load = 1'b1; burst_len = 16'd3;
            @(negedge clk);
            cfg_load = 1'b0; enable = 1'b1;
            bz = 0; pd = 0; bd = 0; co = 0; hi = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                bz += int'(busy); pd += int'(period_done); bd += int'(burst_done);
                co += int'(burst_done && period_done); hi += int'(sig_out);
                @(negedge clk);
            end
            chk("burst_busy", bz, 12);
            chk("burst_period_done", pd, 3);
            chk("burst_done", bd, 1);
            chk("burst_coincident", co, 1);
            chk("burst_sig_high", hi, 6);
            enable = 1'b0;
            @(negedge clk);
            enable = 1'b1;
            @(posedge clk); #1;
            chk("burst_rearm", busy, 1);
            @(negedge clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/pwm_tx.md
Name: pwm_tx

Overview:
- Programmable pulse generator; transmit-side counterpart of the high/low-width measurement block.
- Drives sig_out with a high phase of exactly cfg_high clocks and a low phase of exactly cfg_low clocks, repeating.
- Used as a stimulus source for the frequency/duty meter and as an on-board PWM output.
- New configurations are double-buffered and take effect only at a period boundary, so output periods are never torn.

Parameters:
- CW, 32, width of the high/low count fields and the phase counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = generate periods, 0 = stop after the current period.
- cfg_high  in  CW  high-phase length in clocks.
- cfg_low  in  CW  low-phase length in clocks.
- cfg_load  in  1  one-cycle strobe; captures cfg_high/cfg_low into the pending registers.
- sig_out  out  1  registered generated waveform.
- rise_pulse  out  1  registered; 1 in the first clock sig_out is high after a low or idle clock.
- fall_pulse  out  1  registered; 1 in the first clock sig_out is low after a high clock.
- period_done  out  1  registered; 1 during the last clock of each completed period.
- busy  out  1  1 while the state is not IDLE.
- cfg_pending  out  1  1 from cfg_load until the pending values are copied into the active registers.

Behaviour:
- Reset values:
  - All outputs = 0; state = IDLE.
  - Pending, active and phase counter registers = 0.
- Registers:
  - pend_h/pend_l: written on cfg_load; sets cfg_pending.
  - act_h/act_l: loaded from pend_h/pend_l at every period start; clears cfg_pending.
  - If cfg_load coincides with a period start, the newly strobed values are the ones loaded.
- States: IDLE, HIGH, LOW. cnt counts clocks elapsed in the current phase, 1-based.
- Period start occurs on:
  - IDLE with enable=1 and (next act_h|act_l) != 0; or
  - end of a period with enable=1.
  - At period start: if act_h > 0, enter HIGH with sig_out=1 and cnt=1; else enter LOW with sig_out=0 and cnt=1.
- HIGH phase: cnt increments each clock. When cnt == act_h:
  - if act_l > 0, next clock enters LOW with cnt=1;
  - otherwise this is the end of the period.
- LOW phase: when cnt == act_l, this is the end of the period.
- End of period:
  - period_done = 1 in that clock.
  - Next clock: a new period start if enable=1, otherwise IDLE with sig_out=0.
- Latency: enable rising in cycle t produces sig_out=1 at the edge ending cycle t, visible in cycle t+1.
- Zero cases:
  - act_h=0, act_l>0: sig_out stays 0; period_done every act_l clocks.
  - act_l=0, act_h>0: sig_out stays 1; period_done every act_h clocks; no fall_pulse between periods.
  - Both 0: remain in or return to IDLE; no pulses.
- Timing:
  - Output period = act_h + act_l clocks, exact; no dead cycle between consecutive periods.
  - cnt is CW bits wide, so phase lengths up to 2^CW-1 are legal with no wrap.
- Deasserting enable mid-period: the current period completes unchanged, then IDLE; re-asserting enable before the end continues seamlessly.
- rst asserted mid-operation: immediate return to reset values, sig_out=0 asynchronously.

Optional Feature:
- Macro: PWM_TX_BURST_EN.
- With the macro defined:
  - Extra input burst_len (16 bit) and output burst_done (1 bit, registered pulse).
  - burst_len is sampled at the IDLE-to-active transition; 0 means continuous.
  - After burst_len periods the block returns to IDLE, pulsing burst_done in the same clock as the final period_done.
  - Re-arming requires enable low for at least one clock, then high.
- Without the macro: ports absent; generation is continuous while enable=1.

Test Plan:
- Duty: cfg_load (high=3, low=5), enable=1 → sig_out 1,1,1,0,0,0,0,0 repeating; period_done every 8 clocks; rise_pulse and fall_pulse exactly once per period.
- Reconfig: running 3/5, cfg_load (2/2) mid-HIGH → current 3/5 period completes intact, next period is 2/2; cfg_pending clears at that boundary.
- Zero cases:
  - high=0, low=4 → sig_out constant 0, period_done every 4 clocks.
  - high=4, low=0 → sig_out constant 1 with no fall_pulse.
  - 0/0 → busy=0.
- Stop: enable dropped in the 2nd low clock of a 3/5 period → 3 more low clocks, then IDLE; busy falls the clock after period_done.
- Reset: rst pulsed during HIGH of a 10/10 period → sig_out=0 immediately, all outputs and registers zero, no output until a new cfg_load plus enable.
- Burst (PWM_TX_BURST_EN): burst_len=3, 2/2 config → exactly 12 clocks of waveform, 3 period_done pulses, burst_done coincident with the 3rd.
